// File: rtl/led_scan_scheduler.sv
// Multiplexed 8-digit 7-segment scanner with a double-buffered display image.
// Define LED_SCAN_DIM_PWM_EN to add the 4-bit brightness input for per-slot anode dimming.
module led_scan_scheduler #(
  parameter int unsigned DIV          = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_data,
  input  logic [7:0]  load_dp,
  input  logic [7:0]  load_en,
`ifdef LED_SCAN_DIM_PWM_EN
  input  logic [3:0]  brightness,
`endif
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  typedef enum logic [1:0] {IDLE, DRIVE, BLANK} state_t;

  localparam logic [15:0] DRIVE_LAST = 16'(DIV - 1);
  localparam logic [15:0] BLANK_LAST = 16'(BLANK_CYCLES - 1);

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] drive_cnt_q, drive_cnt_d;
  logic [15:0] blank_cnt_q, blank_cnt_d;

  logic [31:0] pend_data_q, pend_data_d, act_data_q, act_data_d;
  logic [7:0]  pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic [7:0]  pend_en_q, pend_en_d, act_en_q, act_en_d;
  logic        pend_full_q, pend_full_d;

  logic [7:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic        frame_done_q, frame_done_d;

  logic        load_fire, xfer, pwm_on;
  logic [3:0]  nibble;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

`ifdef LED_SCAN_DIM_PWM_EN
  logic [20:0] pwm_lim;
  assign pwm_lim = ((21'(brightness) + 21'd1) * 21'(DIV)) >> 4;
  assign pwm_on  = {5'b0, drive_cnt_d} < pwm_lim;
`else
  assign pwm_on  = 1'b1;
`endif

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    drive_cnt_d  = drive_cnt_q;
    blank_cnt_d  = blank_cnt_q;
    pend_data_d  = pend_data_q;
    pend_dp_d    = pend_dp_q;
    pend_en_d    = pend_en_q;
    pend_full_d  = pend_full_q;
    act_data_d   = act_data_q;
    act_dp_d     = act_dp_q;
    act_en_d     = act_en_q;

    load_fire = load_valid && !pend_full_q;
    xfer      = (state_q == BLANK) && (idx_q == 3'd7) && (blank_cnt_q == BLANK_LAST);

    // load_fire needs pending empty, xfer needs it full, so the two never collide
    if (load_fire) begin
      pend_data_d = load_data;
      pend_dp_d   = load_dp;
      pend_en_d   = load_en;
      pend_full_d = 1'b1;
    end
    if (xfer && pend_full_q) begin
      act_data_d  = pend_data_q;
      act_dp_d    = pend_dp_q;
      act_en_d    = pend_en_q;
      pend_full_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        state_d     = DRIVE;
        idx_d       = 3'd0;
        drive_cnt_d = '0;
      end
      DRIVE: begin
        if (drive_cnt_q == DRIVE_LAST) begin
          state_d     = BLANK;
          blank_cnt_d = '0;
        end else begin
          drive_cnt_d = drive_cnt_q + 16'd1;
        end
      end
      BLANK: begin
        if (blank_cnt_q == BLANK_LAST) begin
          state_d     = DRIVE;
          idx_d       = idx_q + 3'd1;
          drive_cnt_d = '0;
        end else begin
          blank_cnt_d = blank_cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are derived from next-state values so they register on the same edge as the FSM
    nibble = act_data_d[{idx_d, 2'b00} +: 4];
    an_d   = '1;
    seg_d  = '1;
    dp_d   = 1'b1;
    if (state_d == DRIVE) begin
      an_d[idx_d] = ~(act_en_d[idx_d] && pwm_on);
      seg_d       = hex7(nibble);
      dp_d        = ~act_dp_d[idx_d];
    end
    frame_done_d = (state_d == BLANK) && (idx_d == 3'd7) && (blank_cnt_d == BLANK_LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      drive_cnt_q  <= '0;
      blank_cnt_q  <= '0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_en_q    <= '0;
      pend_full_q  <= 1'b0;
      act_data_q   <= '0;
      act_dp_q     <= '0;
      act_en_q     <= '0;
      an_q         <= '1;
      seg_q        <= '1;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      drive_cnt_q  <= drive_cnt_d;
      blank_cnt_q  <= blank_cnt_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_en_q    <= pend_en_d;
      pend_full_q  <= pend_full_d;
      act_data_q   <= act_data_d;
      act_dp_q     <= act_dp_d;
      act_en_q     <= act_en_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign load_ready = ~pend_full_q;
  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_led_scan_scheduler.sv
// Scoreboard bench for led_scan_scheduler: a frame-position model predicts every output cycle.
module tb_led_scan_scheduler;
  localparam int unsigned DIV   = 4;
  localparam int unsigned BL    = 2;
  localparam int unsigned SLOT  = DIV + BL;
  localparam int unsigned FRAME = 8 * SLOT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0;
  logic [31:0] load_data = '0;
  logic [7:0]  load_dp = '0;
  logic [7:0]  load_en = '0;
  logic        load_ready;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;
`ifdef LED_SCAN_DIM_PWM_EN
  logic [3:0]  brightness = 4'hF;
`endif

  always #5 clk = ~clk;

  led_scan_scheduler #(.DIV(DIV), .BLANK_CYCLES(BL)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_dp(load_dp), .load_en(load_en),
`ifdef LED_SCAN_DIM_PWM_EN
    .brightness(brightness),
`endif
    .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
  );

  typedef struct {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
    logic       rdy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  // Model state: k = edges since reset released (0 means still idle after reset)
  int unsigned k = 0;
  logic        pf = 1'b0;
  logic [31:0] pd = '0, ad = '0;
  logic [7:0]  pdp = '0, pen = '0, adp = '0, aen = '0;

  // Lit segments (active-high, bit0=a) for each hex digit
  logic [6:0] seg_on [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  initial begin : model
    exp_t        e;
    int unsigned p, slot;
    logic        fire, xfer;
    logic [31:0] sh;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        k = 0; pf = 1'b0; pd = '0; pdp = '0; pen = '0; ad = '0; adp = '0; aen = '0;
      end else begin
        fire = load_valid && !pf;
        xfer = (k >= 1) && (((k - 1) % FRAME) == FRAME - 1) && pf;
        if (fire) begin pd = load_data; pdp = load_dp; pen = load_en; pf = 1'b1; end
        if (xfer) begin ad = pd; adp = pdp; aen = pen; pf = 1'b0; end
        k++;
      end
      e.an = 8'hFF; e.seg = 7'h7F; e.dp = 1'b1; e.fd = 1'b0; e.rdy = !pf;
      if (k > 0) begin
        p = (k - 1) % FRAME;
        slot = p / SLOT;
        e.fd = (p == FRAME - 1);
        if ((p % SLOT) < DIV) begin
          if (aen[slot]) e.an = ~(8'd1 << slot);
          sh = ad >> (4 * slot);
          e.seg = ~seg_on[sh[3:0]];
          e.dp = ~adp[slot];
        end
      end
      exp_q.push_back(e);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, got, want);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("an", 32'(an), 32'(e.an));
        chk("seg", 32'(seg), 32'(e.seg));
        chk("dp", 32'(dp), 32'(e.dp));
        chk("frame_done", 32'(frame_done), 32'(e.fd));
        chk("load_ready", 32'(load_ready), 32'(e.rdy));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [31:0] d, input logic [7:0] p, input logic [7:0] en);
    load_valid = 1'b1; load_data = d; load_dp = p; load_en = en;
    tick(1);
    load_valid = 1'b0;
  endtask

  initial begin : stim
    bit found;
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2 * FRAME + 5);

    load(32'h76543210, 8'h01, 8'hFF);
    tick(2 * FRAME);

    tick(SLOT * 3 + 1);
    load(32'hFEDCBA98, 8'hA5, 8'hFF);
    tick(3);
    load(32'h11111111, 8'hFF, 8'h0F);
    tick(2 * FRAME);

    load(32'h89ABCDEF, 8'h00, 8'h05);
    tick(3 * FRAME);

    // Line up a reset with the drive phase of digit 3
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      if (k >= 1 && (((k - 1) % FRAME) / SLOT) == 3 && (((k - 1) % SLOT) < DIV)) found = 1'b1;
      else tick(1);
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL reset_align cycle=%0d got=0 expected=1", cyc);
    end
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(FRAME + 7);
    load(32'h0000ABCD, 8'h0F, 8'h0F);
    tick(2 * FRAME);

    for (int i = 0; i < 1500; i++) begin
      load_valid = ($urandom_range(0, 9) < 3);
      load_data  = $urandom;
      load_dp    = 8'($urandom);
      load_en    = 8'($urandom);
      rst_n      = ($urandom_range(0, 299) != 0);
      tick(1);
    end
    load_valid = 1'b0;
    rst_n = 1'b1;
    tick(FRAME);

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_scan_scheduler.md
LED_SCAN_SCHEDULER -- requirements
Module: led_scan_scheduler

Interface
REQ-001 SHALL have parameter DIV, default 50000, meaning clk cycles per digit drive slot (legal range 1..65535).
REQ-002 SHALL have parameter BLANK_CYCLES, default 500, meaning the all-anodes-off dead time after each slot (legal range 1..65535).
REQ-003 SHALL have port clk  input  1  meaning the system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning the reset, which is synchronous and active-low.
REQ-005 SHALL have port load_valid  input  1  meaning the requester offers a new display image.
REQ-006 SHALL have port load_ready  output  1  meaning the pending buffer is empty and can accept an image.
REQ-007 SHALL have port load_data  input  32  meaning the hex nibble for each digit; digit i is [4i+3:4i].
REQ-008 SHALL have port load_dp  input  8  meaning the decimal point for each digit, active-high.
REQ-009 SHALL have port load_en  input  8  meaning the digit enable mask; a 0 keeps that digit dark.
REQ-010 SHALL have port an  output  8  meaning the digit anodes, active-low.
REQ-011 SHALL have port seg  output  7  meaning segments {g,f,e,d,c,b,a}, active-low.
REQ-012 SHALL have port dp  output  1  meaning the decimal point, active-low.
REQ-013 SHALL have port frame_done  output  1  meaning a one-cycle pulse at the end of each 8-digit frame.

Function
REQ-014 SHALL implement FSM states IDLE, DRIVE, BLANK.
REQ-015 SHALL leave IDLE on the first cycle after reset, entering DRIVE with digit index 0.
REQ-016 In DRIVE, SHALL stay exactly DIV cycles, then enter BLANK.
REQ-017 In BLANK, SHALL stay exactly BLANK_CYCLES cycles, then enter DRIVE with the next digit index.
REQ-018 SHALL wrap the digit index from 7 to 0.
REQ-019 SHALL define a frame as 8*(DIV+BLANK_CYCLES) cycles.
REQ-020 In DRIVE, SHALL assert an[idx]=0 only if active_en[idx]=1; all other anodes SHALL be 1.
REQ-021 In DRIVE, SHALL drive seg from the hex decode of the active nibble and dp from the inverted active dp bit.
REQ-022 In IDLE and BLANK, SHALL drive an=8'hFF, seg=7'h7F, dp=1.
REQ-023 SHALL use the standard hex decode, e.g. 0->7'b1000000, 8->7'b0000000, A->7'b0001000, F->7'b0001110.
REQ-024 All outputs SHALL be registered; an, seg and dp change on the same edge.
REQ-025 SHALL implement double buffering: pending registers (data, dp, en, pending_full) and active registers.
REQ-026 SHALL set load_ready = ~pending_full.
REQ-027 SHALL capture an image into pending and set pending_full when load_valid && load_ready.
REQ-028 At the last BLANK cycle of digit 7, SHALL pulse frame_done=1 for one cycle.
REQ-029 On that same cycle, if pending_full=1, SHALL copy pending to active and clear pending_full.
REQ-030 Because load_ready is low on that cycle, a simultaneous load_valid SHALL NOT be accepted; it is accepted on a later cycle.
REQ-031 load_valid with load_ready=0 SHALL have no effect; pending SHALL NOT be overwritten.
REQ-032 Drive and blank counters SHALL each be 16 bits and SHALL NOT overflow within legal parameter ranges.

Reset
REQ-033 When rst_n=0 at a clk edge, SHALL apply: state=IDLE, idx=0, counters=0, an=8'hFF, seg=7'h7F, dp=1.
REQ-034 SHALL also apply on that edge: frame_done=0, load_ready=1, pending_full=0, and all active and pending registers=0.
REQ-035 Reset mid-frame SHALL abort the slot; an returns to 8'hFF on the reset edge, and any pending image is discarded.
REQ-036 Because active_en resets to 0, the display SHALL stay dark until the first image reaches active.

Configuration
REQ-037 SHALL support macro LED_SCAN_DIM_PWM_EN.
REQ-038 When LED_SCAN_DIM_PWM_EN is defined, SHALL add input port brightness (4 bits).
REQ-039 With the macro defined, SHALL assert the anode in DRIVE only while drive_cnt < ((brightness+1)*DIV)>>4, and hold it off for the rest of the slot.
REQ-040 With the macro defined, brightness=15 SHALL give full DRIVE width.
REQ-041 When the macro is undefined, SHALL omit the port and assert the anode for the full DRIVE slot; timing is otherwise identical.

Verification (DIV=4, BLANK_CYCLES=2; frame = 48 cycles)
REQ-042 SHALL verify reset: hold rst_n=0 for 3 cycles, then release with no load -> an=8'hFF throughout, frame_done pulses every 48 cycles, load_ready=1.
REQ-043 SHALL verify scan: load data=32'h76543210, en=8'hFF, dp=8'h01 -> from the next frame, digit 0 shows an=8'hFE, seg=7'b1000000, dp=0 for 4 cycles, then 2 cycles of an=8'hFF.
REQ-044 SHALL verify the scan continues: digit 1 follows with an=8'hFD and seg=7'b1111001.
REQ-045 SHALL verify buffering: issue a second load mid-frame, then a third -> the third sees load_ready=0.
REQ-046 SHALL verify the buffering result: the second image appears only after frame_done, the third is not captured, and load_ready returns to 1 on the transfer cycle +1.
REQ-047 SHALL verify the mask: en=8'h05 -> only an=8'hFE and an=8'hFB ever appear, in slots 0 and 2.
REQ-048 SHALL verify reset mid-frame: assert rst_n=0 during DRIVE of digit 3 -> next edge an=8'hFF and active cleared; display stays dark until a new load is transferred.
REQ-049 SHALL verify PWM (macro defined, DIV=16): brightness=3 -> anode low for 4 of 16 DRIVE cycles; brightness=15 -> low for all 16.
